wb_arbiter_2m: RTL



---
 rtl/wb_arbiter_2m.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/wb_arbiter_2m.sv
// wb_arbiter_2m: two-master / one-slave pipelined Wishbone arbiter.
// M0 (instruction fetch) and M1 (load/store) share one 32-bit slave. The owner
// holds the bus for a whole cyc. Every hand-over passes through one IDLE cycle.
// An outstanding counter stops the owner from issuing more than MAX_OUTST
// un-acked strobes.
// Optional feature: define WBARB_ROUND_ROBIN_EN to replace fixed M0 priority
// with alternating grants on ties.
module wb_arbiter_2m #(
  parameter int MAX_OUTST = 4
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_m0_cyc,
  input  logic        i_m0_stb,
  input  logic        i_m0_we,
  input  logic [31:0] i_m0_addr,
  input  logic [3:0]  i_m0_sel,
  input  logic [31:0] i_m0_data,
  output logic        o_m0_ack,
  output logic        o_m0_err,
  output logic        o_m0_stall,
  output logic [31:0] o_m0_data,
  input  logic        i_m1_cyc,
  input  logic        i_m1_stb,
  input  logic        i_m1_we,
  input  logic [31:0] i_m1_addr,
  input  logic [3:0]  i_m1_sel,
  input  logic [31:0] i_m1_data,
  output logic        o_m1_ack,
  output logic        o_m1_err,
  output logic        o_m1_stall,
  output logic [31:0] o_m1_data,
  output logic        o_s_cyc,
  output logic        o_s_stb,
  output logic        o_s_we,
  output logic [31:0] o_s_addr,
  output logic [3:0]  o_s_sel,
  output logic [31:0] o_s_data,
  input  logic        i_s_ack,
  input  logic        i_s_err,
  input  logic        i_s_stall,
  input  logic [31:0] i_s_data,
  output logic [1:0]  o_owner
);
  localparam int CW = $clog2(MAX_OUTST + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_OUTST);

  // Encoding doubles as the o_owner value.
  typedef enum logic [1:0] {IDLE = 2'b00, OWN0 = 2'b01, OWN1 = 2'b10} state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic            full, accept, resp, own_cyc, tie_m1;
`ifdef WBARB_ROUND_ROBIN_EN
  logic            last_m1, last_m1_nxt;
`endif

  assign full = (cnt == CNT_MAX);

  // State, outstanding count and last grant; reset drops the bus immediately.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
`ifdef WBARB_ROUND_ROBIN_EN
      last_m1 <= 1'b1;
`endif
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
`ifdef WBARB_ROUND_ROBIN_EN
      last_m1 <= last_m1_nxt;
`endif
    end
  end

  // Arbitration, release and counter bookkeeping.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    accept    = o_s_stb & ~i_s_stall;
    // Responses in IDLE are dropped, so they never touch the counter.
    resp      = (state != IDLE) & (i_s_ack | i_s_err);
    own_cyc   = (state == OWN0) ? i_m0_cyc : i_m1_cyc;
`ifdef WBARB_ROUND_ROBIN_EN
    last_m1_nxt = last_m1;
    tie_m1      = ~last_m1;
`else
    tie_m1      = 1'b0;
`endif
    case (state)
      IDLE: begin
        cnt_nxt = '0;
        if (i_m0_cyc && i_m1_cyc) state_nxt = tie_m1 ? OWN1 : OWN0;
        else if (i_m0_cyc)        state_nxt = OWN0;
        else if (i_m1_cyc)        state_nxt = OWN1;
      end
      OWN0, OWN1: begin
        if (!own_cyc) begin
          // Release: an early drop with strobes in flight is silently abandoned.
          state_nxt = IDLE;
          cnt_nxt   = '0;
`ifdef WBARB_ROUND_ROBIN_EN
          last_m1_nxt = (state == OWN1);
`endif
        end else if (accept && !resp) begin
          cnt_nxt = cnt + CW'(1);
        end else if (resp && !accept && cnt != '0) begin
          cnt_nxt = cnt - CW'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Bus steering: owner mirrors to the slave, the other master is held off.
  always_comb begin
    o_s_cyc    = 1'b0;
    o_s_stb    = 1'b0;
    o_s_we     = 1'b0;
    o_s_addr   = '0;
    o_s_sel    = '0;
    o_s_data   = '0;
    o_m0_ack   = 1'b0;
    o_m0_err   = 1'b0;
    o_m0_data  = '0;
    o_m0_stall = i_m0_cyc;
    o_m1_ack   = 1'b0;
    o_m1_err   = 1'b0;
    o_m1_data  = '0;
    o_m1_stall = i_m1_cyc;
    o_owner    = state;
    case (state)
      OWN0: begin
        o_s_cyc    = i_m0_cyc;
        o_s_stb    = i_m0_stb & ~full;
        o_s_we     = i_m0_we;
        o_s_addr   = i_m0_addr;
        o_s_sel    = i_m0_sel;
        o_s_data   = i_m0_data;
        o_m0_stall = i_s_stall | full;
        o_m0_ack   = i_s_ack;
        o_m0_err   = i_s_err;
        o_m0_data  = i_s_data;
      end
      OWN1: begin
        o_s_cyc    = i_m1_cyc;
        o_s_stb    = i_m1_stb & ~full;
        o_s_we     = i_m1_we;
        o_s_addr   = i_m1_addr;
        o_s_sel    = i_m1_sel;
        o_s_data   = i_m1_data;
        o_m1_stall = i_s_stall | full;
        o_m1_ack   = i_s_ack;
        o_m1_err   = i_s_err;
        o_m1_data  = i_s_data;
      end
      default: ;
    endcase
  end
endmodule
